// File: rtl/l2_ram_mp_pkg.sv
// Shared types and address-decode helpers for the interleaved multi-port L2 RAM.
package l2_ram_mp_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefNumBanks  = 4;
    localparam int unsigned DefNumWords  = 1024;

    localparam int unsigned OFF      = $clog2(DefDataWidth / 8);
    localparam int unsigned BankBits = $clog2(DefNumBanks);
    localparam int unsigned WordBits = $clog2(DefNumWords);

    // Wide enough for the largest supported bank count (16) and word count.
    typedef logic [3:0]  bank_idx_t;
    typedef logic [31:0] word_idx_t;

    // Bank index sits directly above the byte offset, so consecutive words
    // land in consecutive banks.
    function automatic bank_idx_t get_bank(input logic [63:0] addr,
                                           input int unsigned off,
                                           input int unsigned bank_bits);
        logic [63:0] mask;
        mask = (64'd1 << bank_bits) - 64'd1;
        return bank_idx_t'((addr >> off) & mask);
    endfunction

    // Word index sits above the bank bits.
    function automatic word_idx_t get_word(input logic [63:0] addr,
                                           input int unsigned off,
                                           input int unsigned bank_bits,
                                           input int unsigned word_bits);
        logic [63:0] mask;
        mask = (64'd1 << word_bits) - 64'd1;
        return word_idx_t'((addr >> (off + bank_bits)) & mask);
    endfunction

    // Anything at or beyond the total region size gets an error response.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] limit);
        return addr < limit;
    endfunction

endpackage

// File: rtl/l2_bank_rr_arb.sv
// Round-robin arbiter for one bank: picks the first requester at or after
// the pointer and moves the pointer just past the winner.
module l2_bank_rr_arb #(
    parameter int unsigned NumPorts = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] req_i,
    output logic [NumPorts-1:0] gnt_o
);

    localparam int unsigned PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] next_ptr;
    logic            found;
    int unsigned     idx;

    // Cyclic search for the winner starting at the current pointer.
    always_comb begin
        gnt_o    = '0;
        next_ptr = ptr_q;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            idx = (int'(ptr_q) + i) % NumPorts;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                next_ptr   = PtrW'((idx + 1) % NumPorts);
            end
        end
    end

    // Pointer only advances when something was granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= next_ptr;
        end
    end

endmodule

// File: rtl/l2_ram_multiport_interleaved.sv
// Word-interleaved multi-bank L2 SRAM with independent request/grant ports,
// per-bank round-robin arbitration and an optional output register stage.
module l2_ram_multiport_interleaved
    import l2_ram_mp_pkg::*;
#(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned NumBanks  = 4,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter bit          OutReg    = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               req_i,
    output logic [NumPorts-1:0]               gnt_o,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    input  logic [NumPorts*DataWidth/8-1:0]   be_i,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [NumPorts*DataWidth-1:0]     rdata_o,
    output logic [NumPorts-1:0]               err_o
);

    localparam int unsigned ByteW     = DataWidth / 8;
    localparam int unsigned Off       = $clog2(ByteW);
    localparam int unsigned BankBitsP = $clog2(NumBanks);
    localparam int unsigned WordBitsP = $clog2(NumWords);
    localparam int unsigned WordW     = (WordBitsP > 0) ? WordBitsP : 1;
    localparam logic [63:0] Limit     = 64'(NumBanks) * 64'(NumWords) * 64'(ByteW);

    bank_idx_t            port_bank [NumPorts];
    logic [WordW-1:0]     port_word [NumPorts];
    logic [NumPorts-1:0]  port_inr;
    logic [NumPorts-1:0]  port_bank_gnt;

    logic [NumPorts-1:0]  bank_req [NumBanks];
    logic [NumPorts-1:0]  bank_gnt [NumBanks];
    logic [DataWidth-1:0] bank_rdata [NumBanks];

    logic [NumPorts-1:0]           s0_valid;
    logic [NumPorts-1:0]           s0_err;
    logic [NumPorts-1:0]           s0_read;
    bank_idx_t                     s0_bank [NumPorts];
    logic [NumPorts*DataWidth-1:0] s0_rdata;

    logic [NumPorts-1:0]           out_valid;
    logic [NumPorts-1:0]           out_err;
    logic [NumPorts*DataWidth-1:0] out_rdata;

    // Split every port's byte address into bank, word and range check.
    always_comb begin
        port_inr = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            port_bank[p] = get_bank(64'(addr_i[p*AddrWidth +: AddrWidth]), Off, BankBitsP);
            port_word[p] = WordW'(get_word(64'(addr_i[p*AddrWidth +: AddrWidth]),
                                           Off, BankBitsP, WordBitsP));
            port_inr[p]  = in_range(64'(addr_i[p*AddrWidth +: AddrWidth]), Limit);
        end
    end

    // Route in-range requests to the bank they address; nothing competes during reset.
    always_comb begin
        for (int b = 0; b < int'(NumBanks); b++) begin
            bank_req[b] = '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                bank_req[b][p] = req_i[p] && port_inr[p] && !rst_i &&
                                 (port_bank[p] == bank_idx_t'(b));
            end
        end
    end

    // Out-of-range requests bypass arbitration and are granted immediately.
    always_comb begin
        port_bank_gnt = '0;
        gnt_o         = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                port_bank_gnt[p] = port_bank_gnt[p] | bank_gnt[b][p];
            end
            gnt_o[p] = req_i[p] && !rst_i && (!port_inr[p] || port_bank_gnt[p]);
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [DataWidth-1:0] mem [NumWords];
        logic [DataWidth-1:0] rdata_q;
        logic                 sel_valid;
        logic                 sel_we;
        logic [WordW-1:0]     sel_word;
        logic [DataWidth-1:0] sel_wdata;
        logic [ByteW-1:0]     sel_be;

        l2_bank_rr_arb #(
            .NumPorts (NumPorts)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b])
        );

        // The one-hot grant steers the winning port's fields onto the bank.
        always_comb begin
            sel_valid = 1'b0;
            sel_we    = 1'b0;
            sel_word  = '0;
            sel_wdata = '0;
            sel_be    = '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                if (bank_gnt[b][p]) begin
                    sel_valid = 1'b1;
                    sel_we    = we_i[p];
                    sel_word  = port_word[p];
                    sel_wdata = wdata_i[p*DataWidth +: DataWidth];
                    sel_be    = be_i[p*ByteW +: ByteW];
                end
            end
        end

        // Single-port SRAM with one cycle read latency; contents survive reset.
        always_ff @(posedge clk_i) begin
            if (sel_valid) begin
                if (sel_we) begin
                    for (int k = 0; k < int'(ByteW); k++) begin
                        if (sel_be[k]) begin
                            mem[sel_word][k*8 +: 8] <= sel_wdata[k*8 +: 8];
                        end
                    end
                end else begin
                    rdata_q <= mem[sel_word];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // First response stage: remembers what each grant was and which bank to read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s0_valid <= '0;
            s0_err   <= '0;
            s0_read  <= '0;
            for (int p = 0; p < int'(NumPorts); p++) begin
                s0_bank[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                s0_valid[p] <= gnt_o[p];
                s0_err[p]   <= gnt_o[p] && !port_inr[p];
                s0_read[p]  <= gnt_o[p] && port_inr[p] && !we_i[p];
                s0_bank[p]  <= port_bank[p];
            end
        end
    end

    // Pick read data from the bank this port was granted; writes and errors return zero.
    always_comb begin
        s0_rdata = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            for (int b = 0; b < int'(NumBanks); b++) begin
                if (s0_read[p] && (s0_bank[p] == bank_idx_t'(b))) begin
                    s0_rdata[p*DataWidth +: DataWidth] = bank_rdata[b];
                end
            end
        end
    end

    if (OutReg) begin : g_outreg
        logic [NumPorts-1:0]           s1_valid;
        logic [NumPorts-1:0]           s1_err;
        logic [NumPorts*DataWidth-1:0] s1_rdata;

        // Optional extra register stage for timing closure toward the interconnect.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                s1_valid <= '0;
                s1_err   <= '0;
                s1_rdata <= '0;
            end else begin
                s1_valid <= s0_valid;
                s1_err   <= s0_err;
                s1_rdata <= s0_rdata;
            end
        end

        assign out_valid = s1_valid;
        assign out_err   = s1_err;
        assign out_rdata = s1_rdata;
    end else begin : g_noreg
        assign out_valid = s0_valid;
        assign out_err   = s0_err;
        assign out_rdata = s0_rdata;
    end

    // Responses are suppressed while reset is held so nothing in flight leaks out.
    always_comb begin
        rvalid_o = rst_i ? '0 : out_valid;
        err_o    = rst_i ? '0 : out_err;
        rdata_o  = rst_i ? '0 : out_rdata;
    end

endmodule
